// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch stage.
// Holds the NOP encoding, FSM states and the IF/ID bundle.
package fetch_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_ISSUE = 2'd0,
        S_WAIT  = 2'd1,
        S_DROP  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{
        inst:  NOP_INST,
        pc:    32'h0,
        pc4:   32'h0,
        valid: 1'b0
    };

    // Build a valid IF/ID entry; pc4 wraps modulo 2^32.
    function automatic ifid_t make_ifid(
        input logic [31:0] inst,
        input logic [31:0] pc
    );
        make_ifid = '{
            inst:  inst,
            pc:    pc,
            pc4:   pc + 32'd4,
            valid: 1'b1
        };
    endfunction

endpackage

// File: rtl/fetch_ff_FD.sv
// fetch_ff_FD: IF/ID pipeline register.
// Flush beats stall; a stalled register keeps its contents.
module fetch_ff_FD
    import fetch_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst_n,
    input  logic  i_stall,
    input  logic  i_flush,
    input  ifid_t i_d,
    output ifid_t o_q
);

    ifid_t r_q;

    // IF/ID register: flush loads a bubble, stall holds, else load.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= IFID_BUBBLE;
        end else if (i_flush) begin
            r_q <= IFID_BUBBLE;
        end else if (!i_stall) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, one-outstanding imem fetch FSM, hold buffer, IF/ID.
// Define FETCH_PERF_CNT_EN to add the o_bubble_cnt output.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_instD,
    output logic [31:0] o_pcD,
    output logic [31:0] o_pc4D,
    output logic        o_validD,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] o_bubble_cnt,
`endif
    output logic        o_fetch_busy
);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_nxt;
    logic [31:0]  w_pc_inc;
    logic [31:0]  w_addr;
    logic         w_req;
    logic         w_accept;
    logic         w_to_hold;
    logic         w_kill;
    logic         w_drain;
    logic         r_hold_valid;
    logic [31:0]  r_hold_inst;
    logic [31:0]  r_hold_pc;
    ifid_t        w_ifid_d;
    ifid_t        w_ifid_q;

    assign w_pc_inc = r_pc + 32'd4;
    assign w_kill   = i_flush | i_redirect;
    assign w_drain  = r_hold_valid & ~w_kill & ~i_stall;

    // State and PC registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_ISSUE;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // Next state, next PC and request generation; redirect wins.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_req       = 1'b0;
        w_addr      = r_pc;
        w_accept    = 1'b0;
        w_to_hold   = 1'b0;
        unique case (r_state)
            S_ISSUE: begin
                if (i_redirect) begin
                    w_pc_nxt = i_redirect_pc;
                end else if (!r_hold_valid) begin
                    w_req       = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_redirect) begin
                    w_pc_nxt    = i_redirect_pc;
                    w_state_nxt = i_imem_rvalid ? S_ISSUE : S_DROP;
                end else if (i_imem_rvalid && !i_stall
                             && !r_hold_valid) begin
                    w_accept = 1'b1;
                    w_pc_nxt = w_pc_inc;
                    w_req    = 1'b1;
                    w_addr   = w_pc_inc;
                end else if (i_imem_rvalid) begin
                    w_to_hold   = 1'b1;
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_DROP: begin
                if (i_redirect) begin
                    w_pc_nxt = i_redirect_pc;
                end
                if (i_imem_rvalid) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            default: begin
                w_state_nxt = S_ISSUE;
            end
        endcase
    end

    // Hold buffer: parks a response that arrived during a stall.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hold_valid <= 1'b0;
            r_hold_inst  <= 32'h0;
            r_hold_pc    <= 32'h0;
        end else if (i_redirect) begin
            r_hold_valid <= 1'b0;
        end else if (w_to_hold) begin
            r_hold_valid <= 1'b1;
            r_hold_inst  <= i_imem_rdata;
            r_hold_pc    <= r_pc;
        end else if (w_drain) begin
            r_hold_valid <= 1'b0;
        end
    end

    // IF/ID input select: hold entry, then fresh response, else bubble.
    always_comb begin
        w_ifid_d = IFID_BUBBLE;
        if (r_hold_valid) begin
            w_ifid_d = make_ifid(r_hold_inst, r_hold_pc);
        end else if (w_accept) begin
            w_ifid_d = make_ifid(i_imem_rdata, r_pc);
        end
    end

    fetch_ff_FD u_ff_fd (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_stall (i_stall),
        .i_flush (w_kill),
        .i_d     (w_ifid_d),
        .o_q     (w_ifid_q)
    );

    assign o_imem_req   = w_req & i_rst_n;
    assign o_imem_addr  = w_addr;
    assign o_instD      = w_ifid_q.inst;
    assign o_pcD        = w_ifid_q.pc;
    assign o_pc4D       = w_ifid_q.pc4;
    assign o_validD     = w_ifid_q.valid;
    assign o_fetch_busy = (r_state != S_ISSUE);

`ifdef FETCH_PERF_CNT_EN
    logic        w_bubble_evt;
    logic [31:0] r_bubble_cnt;

    assign w_bubble_evt = ~w_kill & ~i_stall
                        & ~r_hold_valid & ~w_accept;

    // Saturating count of plain bubbles loaded into IF/ID.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bubble_cnt <= 32'h0;
        end else if (w_bubble_evt
                     && r_bubble_cnt != 32'hFFFF_FFFF) begin
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign o_bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus a randomized stream check.
// Memory responder and instruction-order scoreboard live in the bench.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        stall  = 1'b0;
    logic        flush  = 1'b0;
    logic        redir  = 1'b0;
    logic [31:0] rpc    = 32'h0;
    logic        req;
    logic [31:0] addr;
    logic        rvalid = 1'b0;
    logic [31:0] rdata  = 32'h0;
    logic [31:0] instD;
    logic [31:0] pcD;
    logic [31:0] pc4D;
    logic        validD;
    logic        busy;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] bcnt;
`endif

    int checks = 0;
    int errors = 0;

    int          lat      = 1;
    bit          lat_rand = 1'b0;
    int          cyc      = 0;
    bit          mem_pend = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    int          mem_due  = 0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_stall       (stall),
        .i_flush       (flush),
        .i_redirect    (redir),
        .i_redirect_pc (rpc),
        .o_imem_req    (req),
        .o_imem_addr   (addr),
        .i_imem_rvalid (rvalid),
        .i_imem_rdata  (rdata),
        .o_instD       (instD),
        .o_pcD         (pcD),
        .o_pc4D        (pc4D),
        .o_validD      (validD),
`ifdef FETCH_PERF_CNT_EN
        .o_bubble_cnt  (bcnt),
`endif
        .o_fetch_busy  (busy)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0] ^ 16'h5EED, a[17:2]};
    endfunction

    // Instruction memory: answers each request after lat cycles.
    always begin
        @(posedge clk);
        #1;
        cyc = cyc + 1;
        if (mem_pend && cyc == mem_due) begin
            rvalid   = 1'b1;
            rdata    = memf(mem_addr);
            mem_pend = 1'b0;
        end else begin
            rvalid = 1'b0;
            rdata  = $urandom;
        end
        @(negedge clk);
        #1;
        if (req === 1'b1) begin
            mem_pend = 1'b1;
            mem_addr = addr;
            mem_due  = cyc + (lat_rand ? int'($urandom_range(1, 3)) : lat);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1);
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Holds reset 4 cycles; returns at the start of cycle 0.
    task automatic do_reset();
        stall = 1'b0;
        flush = 1'b0;
        redir = 1'b0;
        rpc   = 32'h0;
        rst_n = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        lat = 1;
        lat_rand = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({req, busy} !== 2'b00) begin
            errors++;
            $display("FAIL rst_req_busy: got %b exp 00", {req, busy});
        end
        do_reset();
        @(negedge clk);
        checks++;
        if ({instD, pcD, pc4D, validD} !== {NOP, 32'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL rst_ifid: got %h %h %h %b", instD, pcD, pc4D, validD);
        end
        checks++;
        if (req !== 1'b1 || addr !== RST_PC) begin
            errors++;
            $display("FAIL rst_first_req: got %b %h exp 1 %h", req, addr, RST_PC);
        end
    endtask

    task automatic test_stream();
        logic [31:0] e;
        lat = 1;
        lat_rand = 1'b0;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            if (c > 0) next_cyc();
            @(negedge clk);
            e = RST_PC + 32'(4 * c);
            checks++;
            if (req !== 1'b1 || addr !== e) begin
                errors++;
                $display("FAIL stream_req c%0d: got %b %h exp 1 %h", c, req, addr, e);
            end
            if (c == 1) begin
                checks++;
                if (validD !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_c1_valid: got %b exp 0", validD);
                end
            end
            if (c >= 2) begin
                e = RST_PC + 32'(4 * (c - 2));
                checks++;
                if ({validD, pcD, pc4D, instD} !== {1'b1, e, e + 32'd4, memf(e)}) begin
                    errors++;
                    $display("FAIL stream_id c%0d: got %b %h %h %h exp pc %h",
                             c, validD, pcD, pc4D, instD, e);
                end
            end
        end
    endtask

    task automatic test_stall();
        lat = 1;
        lat_rand = 1'b0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            if (c > 0) next_cyc();
            stall = (c >= 3 && c <= 5);
            @(negedge clk);
            if (c >= 3 && c <= 6) begin
                checks++;
                if (req !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_noreq c%0d: got %b exp 0", c, req);
                end
                checks++;
                if ({validD, pcD, instD} !== {1'b1, 32'h4, memf(32'h4)}) begin
                    errors++;
                    $display("FAIL stall_hold_id c%0d: got %b %h %h exp pc 4", c, validD, pcD, instD);
                end
            end
            if (c == 4) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_busy: got %b exp 0", busy);
                end
            end
            if (c == 7) begin
                checks++;
                if ({validD, pcD, instD} !== {1'b1, 32'h8, memf(32'h8)}) begin
                    errors++;
                    $display("FAIL stall_drain: got %b %h %h exp pc 8", validD, pcD, instD);
                end
                checks++;
                if (req !== 1'b1 || addr !== 32'hC) begin
                    errors++;
                    $display("FAIL stall_resume_req: got %b %h exp 1 c", req, addr);
                end
            end
            if (c == 9) begin
                checks++;
                if ({validD, pcD} !== {1'b1, 32'hC}) begin
                    errors++;
                    $display("FAIL stall_next_id: got %b %h exp 1 c", validD, pcD);
                end
            end
        end
        stall = 1'b0;
    endtask

    task automatic test_redirect_drop();
        lat = 3;
        lat_rand = 1'b0;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            if (c > 0) next_cyc();
            redir = (c == 4);
            rpc   = 32'h100;
            @(negedge clk);
            if (c == 4) begin
                checks++;
                if ({validD, pcD} !== {1'b1, 32'h0}) begin
                    errors++;
                    $display("FAIL drop_pre_id: got %b %h exp 1 0", validD, pcD);
                end
            end
            if (c == 5) begin
                checks++;
                if ({busy, req, validD, instD} !== {1'b1, 1'b0, 1'b0, NOP}) begin
                    errors++;
                    $display("FAIL drop_state: got busy %b req %b v %b %h", busy, req, validD, instD);
                end
            end
            if (c == 6) begin
                checks++;
                if (req !== 1'b0) begin
                    errors++;
                    $display("FAIL drop_stale_noreq: got %b exp 0", req);
                end
            end
            if (c == 7) begin
                checks++;
                if ({req, addr, validD} !== {1'b1, 32'h100, 1'b0}) begin
                    errors++;
                    $display("FAIL drop_new_req: got %b %h v %b exp 1 100 v 0", req, addr, validD);
                end
            end
            if (c == 11) begin
                checks++;
                if ({validD, pcD, pc4D, instD} !== {1'b1, 32'h100, 32'h104, memf(32'h100)}) begin
                    errors++;
                    $display("FAIL drop_target_id: got %b %h %h %h", validD, pcD, pc4D, instD);
                end
            end
        end
        redir = 1'b0;
    endtask

    task automatic test_redirect_flush();
        lat = 1;
        lat_rand = 1'b0;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            if (c > 0) next_cyc();
            redir = (c == 2);
            flush = (c == 2);
            rpc   = 32'h200;
            @(negedge clk);
            if (c == 2) begin
                checks++;
                if ({busy, req, validD, pcD} !== {1'b1, 1'b0, 1'b1, 32'h0}) begin
                    errors++;
                    $display("FAIL rf_same_cycle: got busy %b req %b v %b pc %h", busy, req, validD, pcD);
                end
            end
            if (c == 3) begin
                checks++;
                if ({busy, req, addr} !== {1'b0, 1'b1, 32'h200}) begin
                    errors++;
                    $display("FAIL rf_reissue: got busy %b req %b %h exp 0 1 200", busy, req, addr);
                end
                checks++;
                if ({validD, instD, pcD, pc4D} !== {1'b0, NOP, 32'h0, 32'h0}) begin
                    errors++;
                    $display("FAIL rf_bubble: got %b %h %h %h", validD, instD, pcD, pc4D);
                end
            end
            if (c == 4) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL rf_busy_back: got %b exp 1", busy);
                end
            end
            if (c == 5) begin
                checks++;
                if ({validD, pcD, instD} !== {1'b1, 32'h200, memf(32'h200)}) begin
                    errors++;
                    $display("FAIL rf_target_id: got %b %h %h", validD, pcD, instD);
                end
            end
        end
        redir = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_wrap();
        lat = 1;
        lat_rand = 1'b0;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            if (c > 0) next_cyc();
            redir = (c == 0);
            rpc   = 32'hFFFF_FFF8;
            @(negedge clk);
            if (c == 0) begin
                checks++;
                if (req !== 1'b0) begin
                    errors++;
                    $display("FAIL wrap_redir_noreq: got %b exp 0", req);
                end
            end
            if (c == 3) begin
                checks++;
                if ({req, addr} !== {1'b1, 32'h0}) begin
                    errors++;
                    $display("FAIL wrap_req: got %b %h exp 1 0", req, addr);
                end
            end
            if (c == 4) begin
                checks++;
                if ({validD, pcD, pc4D} !== {1'b1, 32'hFFFF_FFFC, 32'h0}) begin
                    errors++;
                    $display("FAIL wrap_pc4: got %b %h %h", validD, pcD, pc4D);
                end
            end
        end
        redir = 1'b0;
    endtask

    task automatic test_async_reset();
        lat = 1;
        lat_rand = 1'b0;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            if (c > 0) next_cyc();
            if (c == 2) lat = 3;
            @(negedge clk);
        end
        checks++;
        if ({validD, pcD, busy} !== {1'b1, 32'h4, 1'b1}) begin
            errors++;
            $display("FAIL ar_pre: got v %b pc %h busy %b", validD, pcD, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({instD, pcD, pc4D, validD, req, busy} !== {NOP, 32'h0, 32'h0, 3'b000}) begin
            errors++;
            $display("FAIL ar_immediate: got %h %h %h v%b r%b b%b", instD, pcD, pc4D, validD, req, busy);
        end
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({validD, req} !== 2'b00) begin
                errors++;
                $display("FAIL ar_during: got v %b req %b exp 00", validD, req);
            end
        end
        lat = 1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) next_cyc();
            @(negedge clk);
            if (c == 0) begin
                checks++;
                if ({req, addr} !== {1'b1, RST_PC}) begin
                    errors++;
                    $display("FAIL ar_first_req: got %b %h", req, addr);
                end
            end
            if (c == 2 || c == 3) begin
                checks++;
                if ({validD, pcD, instD} !== {1'b1, 32'(4 * (c - 2)), memf(32'(4 * (c - 2)))}) begin
                    errors++;
                    $display("FAIL ar_after c%0d: got %b %h %h", c, validD, pcD, instD);
                end
            end
        end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        lat = 2;
        lat_rand = 1'b0;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            if (c > 0) next_cyc();
            flush = (c == 1);
            stall = (c == 11 || c == 12);
            @(negedge clk);
            if (c == 0 || c == 11 || c == 13 || c == 15) begin
                checks++;
                if (bcnt !== ((c == 0) ? 32'd0 : (c == 15) ? 32'd6 : 32'd5)) begin
                    errors++;
                    $display("FAIL perf_cnt c%0d: got %0d", c, bcnt);
                end
            end
            if (c == 14) begin
                checks++;
                if ({validD, pcD, bcnt} !== {1'b1, 32'h14, 32'd5}) begin
                    errors++;
                    $display("FAIL perf_drain: got %b %h cnt %0d", validD, pcD, bcnt);
                end
            end
        end
        flush = 1'b0;
        stall = 1'b0;
    endtask
`endif

    task automatic test_random();
        logic [31:0] exp_pc;
        logic [96:0] snap;
        bit          p_stall;
        bit          p_kill;
        int          idle;
        int          delivered;
        lat_rand  = 1'b1;
        do_reset();
        exp_pc    = RST_PC;
        snap      = '0;
        p_stall   = 1'b0;
        p_kill    = 1'b0;
        idle      = 0;
        delivered = 0;
        for (int c = 0; c < 500; c++) begin
            if (c > 0) next_cyc();
            stall = ($urandom_range(0, 3) == 0);
            redir = (c > 2) && ($urandom_range(0, 15) == 0);
            flush = redir;
            rpc   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0
                  : (32'($urandom_range(0, 1023)) << 2);
            @(negedge clk);
            if (p_kill) begin
                checks++;
                if ({validD, instD} !== {1'b0, NOP}) begin
                    errors++;
                    $display("FAIL rnd_kill c%0d: got %b %h", c, validD, instD);
                end
            end else if (p_stall) begin
                checks++;
                if ({validD, instD, pcD, pc4D} !== snap) begin
                    errors++;
                    $display("FAIL rnd_stall_hold c%0d: got %b %h %h", c, validD, instD, pcD);
                end
            end else if (validD === 1'b1) begin
                checks++;
                if ({instD, pcD, pc4D} !== {memf(exp_pc), exp_pc, exp_pc + 32'd4}) begin
                    errors++;
                    $display("FAIL rnd_order c%0d: got %h %h %h exp pc %h", c, instD, pcD, pc4D, exp_pc);
                end
                exp_pc = exp_pc + 32'd4;
                delivered++;
                idle = 0;
            end else begin
                idle++;
            end
            checks++;
            if ((req & mem_pend) !== 1'b0) begin
                errors++;
                $display("FAIL rnd_one_outstanding c%0d: req %b while pending", c, req);
            end
            if (idle > 30) begin
                errors++;
                $display("FAIL rnd_progress: no instruction for %0d cycles", idle);
                break;
            end
            snap    = {validD, instD, pcD, pc4D};
            p_stall = stall;
            p_kill  = redir;
            if (redir) exp_pc = rpc;
        end
        checks++;
        if (delivered < 50) begin
            errors++;
            $display("FAIL rnd_throughput: got %0d exp >= 50", delivered);
        end
        stall = 1'b0;
        redir = 1'b0;
        flush = 1'b0;
        lat_rand = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_drop();
        test_redirect_flush();
        test_wrap();
        test_async_reset();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register.
- Holds the PC and issues one-outstanding requests to instruction memory.
- Presents the fetched instruction to the decode/control path as o_instD, or a NOP bubble when nothing valid is available.
- Applies stall/flush from the hazard unit and PC redirects from EX (taken branch/jal), discarding any in-flight fetch that a redirect kills.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_stall  in  1  hold IF/ID register contents (hazard unit)
- i_flush  in  1  load a bubble into IF/ID
- i_redirect  in  1  EX redirect strobe
- i_redirect_pc  in  32  redirect target
- o_imem_req  out  1  fetch request pulse, one cycle per fetch
- o_imem_addr  out  32  fetch address
- i_imem_rvalid  in  1  response valid, at least 1 cycle after req
- i_imem_rdata  in  32  response instruction
- o_instD  out  32  IF/ID instruction
- o_pcD  out  32  IF/ID PC
- o_pc4D  out  32  IF/ID PC+4
- o_validD  out  1  IF/ID holds a real instruction
- o_fetch_busy  out  1  request outstanding (state S_WAIT or S_DROP)

Behaviour:
- Reset (async, i_rst_n=0):
  - pcF=RESET_PC; state=S_ISSUE; hold buffer empty.
  - o_instD=NOP (32'h0000_0013), o_pcD=0, o_pc4D=0, o_validD=0, o_imem_req=0.
- States:
  - S_ISSUE: no outstanding request.
  - S_WAIT: one request outstanding.
  - S_DROP: outstanding request is killed; its response is discarded.
- In S_ISSUE:
  - i_redirect=1: pcF<=i_redirect_pc, no request, stay S_ISSUE.
  - Else if hold buffer empty: req=1, addr=pcF, go S_WAIT.
  - Else (hold full): no request.
- In S_WAIT, each condition below is evaluated on that cycle's i_redirect/i_imem_rvalid/i_stall; the first match applies:
  - i_redirect=1 (with or without rvalid): drop the response, pcF<=i_redirect_pc. Go S_ISSUE if rvalid=1, else S_DROP.
  - rvalid=1, i_stall=0, hold empty: accept the response into IF/ID, pcF<=pcF+4, same-cycle back-to-back req with addr=pcF+4, stay S_WAIT. This gives 1 instruction/cycle with 1-cycle memory.
  - rvalid=1, i_stall=1: write {rdata, pcF} into the hold buffer, pcF<=pcF+4, go S_ISSUE. Further issue is blocked until the hold buffer drains.
- In S_DROP:
  - On rvalid: discard the response, go S_ISSUE.
  - A redirect in S_DROP updates pcF and stays S_DROP. If it coincides with rvalid, go S_ISSUE.
- IF/ID update priority, highest first:
  1. i_flush or i_redirect: load NOP, valid=0, pcD/pc4D=0.
  2. i_stall: hold current contents.
  3. Hold buffer full: load the hold entry, clear the hold buffer.
  4. Accepted response: load it, valid=1.
  5. Otherwise: bubble.
- Redirect clears the hold buffer.
- Stall without flush never loses the hold buffer or an accepted response.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0. Redirect targets are taken as-is; bits [1:0] are not checked.
- Latency: req in cycle N, rvalid in N+1, o_instD valid in N+2.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds output o_bubble_cnt [31:0]. Reset 0. Increments each cycle IF/ID loads a bubble by rule 5 only (flush/redirect/stall not counted). Saturates at 32'hFFFF_FFFF.
- Undefined: port and counter absent; no other behaviour change.

Decomposition:
- Package fetch_pkg:
  - NOP_INST=32'h0000_0013.
  - Typedef fetch_state_e {S_ISSUE, S_WAIT, S_DROP}.
  - Typedef ifid_t {inst, pc, pc4, valid}.
- One sub-module, fetch_ff_FD: the IF/ID register with stall/flush priority and async active-low reset. The FSM, PC and hold buffer stay in fetch_stage.

Test Plan:
- Reset, 1-cycle memory returning addr-derived data, no stall → req addrs 0,4,8,… on consecutive cycles; o_pcD=0 at cycle 2, then 4, 8; o_validD=1 from cycle 2.
- i_stall=1 for 3 cycles while a response at pc=8 arrives → data captured in the hold buffer, no new req during stall, o_instD unchanged; after release pc=8 enters ID, then fetch resumes at 12.
- Memory latency 3, redirect to 32'h100 one cycle after req for pc=4 → state S_DROP, stale response discarded; next req addr=32'h100, its data reaches ID with o_pcD=32'h100.
- Redirect in the same cycle as rvalid, plus i_flush → response dropped, o_instD=NOP, o_validD=0, next req addr=redirect_pc, o_fetch_busy drops for exactly that cycle.
- i_rst_n asserted mid-S_WAIT → all outputs at reset values immediately (asynchronous). After release, first req addr=RESET_PC; a late rvalid arriving during reset is ignored.
- FETCH_PERF_CNT_EN defined, memory latency 2, 5 fetches → o_bubble_cnt equals the count of bubble cycles by rule 5, excluding stall/flush cycles (5 with this stimulus).
